arm_decode_queue: RTL
=====================

# arm_decode_queue

Parametrised, buffered successor to the combinational ARM instruction classifier. Accepts 32-bit instruction words over a valid/ready handshake, decodes instruction class, data-processing subtype and condition field, and holds the decoded results in a DEPTH-entry FIFO feeding the execute front-end. It sits between fetch and issue, so fetch stalls are decoupled from issue stalls. Optional per-class retire counters support performance bring-up.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of each statistics counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction word present
- in_instr  in  32  instruction word
- in_ready  out  1  queue can accept this cycle
- out_valid  out  1  decoded entry at head
- out_ready  in  1  consumer takes head this cycle
- out_instr  out  32  original word of head entry
- out_class  out  3  instruction class
- out_dp_type  out  4  data-processing subtype
- out_cond  out  4  instr[31:28] of head entry
- level  out  $clog2(DEPTH)+1  current occupancy
- stats_clr  in  1  synchronous clear of all counters
- stats_dp, stats_ls, stats_br, stats_cp  out  CNT_W each  retired-entry counts per class

## Operation
- Class from instr[27:26]: 00→1 (data-proc), 01→2 (load/store), 10→3 (branch/block), 11→0 (coproc/SWI).
- dp_type, first match wins; forced 0 when class≠1:
  - instr[25]=1 → 1 (immediate operand)
  - instr[27:24]=0000 and instr[7:4]=1001 → 4 (multiply)
  - instr[4]=0 → 2 (register, immediate shift)
  - instr[7]=0, instr[4]=1 → 3 (register-shifted register)
  - otherwise → 0 (extension space)
- Decode is performed on entry; FIFO stores instr, class, dp_type, cond.
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = (level < DEPTH); no pass-through when full, even if popping that cycle.
- out_valid = (level ≠ 0); head outputs are stable while out_valid && !out_ready.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Counters: on each pop, increment the counter matching out_class; saturate at all-ones. stats_clr has priority over a same-cycle increment.

## Timing
- Reset (async assert, sync release): level=0, out_valid=0, in_ready=1, pointers=0, all stats=0. out_instr/class/dp_type/cond = 0 while empty.
- Latency: word pushed in cycle N appears at head with out_valid=1 in cycle N+1 if the queue was empty.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all entries discarded, no counter updates for discarded entries.
- Outputs are registered or derived from registered state only; no combinational in→out path. in_ready depends only on level.

## Configuration
- DECODE_STATS_EN defined: counters and stats_clr are implemented as described.
- Not defined: stats_* ports remain, driven constant 0; stats_clr ignored; no counter flops.

## Structure
- Package arm_decode_pkg: class constants (CLS_CP=0, CLS_DP=1, CLS_LS=2, CLS_BR=3), dp_type constants (DP_EXT=0, DP_IMM=1, DP_REGSH=2, DP_REGREG=3, DP_MUL=4), decoded-entry struct, decode function.
- Sub-module arm_decode_fifo: generic DEPTH×payload synchronous FIFO with level output; top holds decode and counters.

## Test plan
- Reset, then push 0xE2811001 → next cycle out_valid=1, out_class=1, out_dp_type=1, out_cond=0xE.
- Push 0xE0010392, 0xE0812003, 0xE0812313 back-to-back, out_ready=1 → heads in order with dp_type 4, 2, 3; level never exceeds 1.
- Push 0xE5912000, 0xEA000000, 0xEF000000 → class 2, 3, 0 with dp_type 0 on all.
- out_ready=0, push DEPTH words → in_ready=0 at level=DEPTH; further in_valid ignored; then pop one with in_valid=1 → no push that cycle, push next cycle; order preserved across pointer wrap.
- With DECODE_STATS_EN, retire 3 DP, 2 LS, 1 BR → stats 3/2/1/0; CNT_W=2 with 5 DP retires → stats_dp saturates at 3; stats_clr coincident with a pop → 0.
- Assert rst with level=3 → level=0, out_valid=0, in_ready=1 immediately; counters unchanged by discarded entries.

Source files
------------

// File: rtl/arm_decode_pkg.sv
// Shared types and the ARM instruction-word classifier used by arm_decode_queue.
package arm_decode_pkg;

    localparam logic [2:0] CLS_CP = 3'd0;
    localparam logic [2:0] CLS_DP = 3'd1;
    localparam logic [2:0] CLS_LS = 3'd2;
    localparam logic [2:0] CLS_BR = 3'd3;

    localparam logic [3:0] DP_EXT    = 4'd0;
    localparam logic [3:0] DP_IMM    = 4'd1;
    localparam logic [3:0] DP_REGSH  = 4'd2;
    localparam logic [3:0] DP_REGREG = 4'd3;
    localparam logic [3:0] DP_MUL    = 4'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  cls;
        logic [3:0]  dp_type;
        logic [3:0]  cond;
    } decoded_t;

    localparam int ENTRY_W = $bits(decoded_t);

    function automatic decoded_t decode(input logic [31:0] instr);
        decoded_t d;
        d.instr   = instr;
        d.cond    = instr[31:28];
        d.dp_type = DP_EXT;
        case (instr[27:26])
            2'b00:   d.cls = CLS_DP;
            2'b01:   d.cls = CLS_LS;
            2'b10:   d.cls = CLS_BR;
            default: d.cls = CLS_CP;
        endcase
        // Priority order matters: multiply encodings also have bit 4 set and bit 7 set.
        if (d.cls == CLS_DP) begin
            if (instr[25])                                     d.dp_type = DP_IMM;
            else if (instr[27:24] == 4'b0000 && instr[7:4] == 4'b1001) d.dp_type = DP_MUL;
            else if (!instr[4])                                d.dp_type = DP_REGSH;
            else if (!instr[7])                                d.dp_type = DP_REGREG;
            else                                               d.dp_type = DP_EXT;
        end
        return d;
    endfunction

endpackage

// File: rtl/arm_decode_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy output; head reads as zero when empty.
module arm_decode_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_en, pop_en;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_en && !pop_en)      level_d = level_q + (AW+1)'(1);
        else if (!push_en && pop_en) level_d = level_q - (AW+1)'(1);
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; stale slots are never visible because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/arm_decode_queue.sv
// Decodes ARM instruction words on entry and buffers them in a DEPTH-entry FIFO.
// Define DECODE_STATS_EN to build the per-class retire counters.
module arm_decode_queue
    import arm_decode_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr,
    output logic                   in_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [2:0]             out_class,
    output logic [3:0]             out_dp_type,
    output logic [3:0]             out_cond,
    output logic [$clog2(DEPTH):0] level,
    input  logic                   stats_clr,
    output logic [CNT_W-1:0]       stats_dp,
    output logic [CNT_W-1:0]       stats_ls,
    output logic [CNT_W-1:0]       stats_br,
    output logic [CNT_W-1:0]       stats_cp
);

    decoded_t           in_entry;
    decoded_t           head;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_full, fifo_empty;
    logic               push, pop;

    assign in_entry  = decode(in_instr);
    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    arm_decode_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (in_entry),
        .rdata_o (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign head        = decoded_t'(head_bits);
    assign out_instr   = head.instr;
    assign out_class   = head.cls;
    assign out_dp_type = head.dp_type;
    assign out_cond    = head.cond;

`ifdef DECODE_STATS_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters are indexed directly by class code; clear wins over a same-cycle retire.
    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr) begin
            for (int i = 0; i < 4; i++) cnt_d[i] = '0;
        end else if (pop && cnt_q[head.cls[1:0]] != '1) begin
            cnt_d[head.cls[1:0]] = cnt_q[head.cls[1:0]] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stats_cp = cnt_q[CLS_CP[1:0]];
    assign stats_dp = cnt_q[CLS_DP[1:0]];
    assign stats_ls = cnt_q[CLS_LS[1:0]];
    assign stats_br = cnt_q[CLS_BR[1:0]];
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign stats_cp = '0;
    assign stats_dp = '0;
    assign stats_ls = '0;
    assign stats_br = '0;
`endif

endmodule
